muldiv_unit: RTL

Iterative multiply/divide unit for the EX stage, operating beside the ALU on the same forwarded operands. It executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers and supports MTHI/MTLO writes. HI/LO feed the EX result mux for MFHI/MFLO, alongside `alu_out`. While `busy` is high, the hazard unit stalls any instruction that touches HI/LO.

---
 rtl/muldiv_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit for the EX stage. Executes MULT, MULTU, DIV
// and DIVU into the architectural HI/LO registers and accepts MTHI/MTLO writes.
//
// Multiply: radix-2 shift-add on a 2*WIDTH accumulator, magnitude arithmetic
//           with a final negate when the operand signs differ.
// Divide:   restoring division on magnitudes; quotient truncates toward zero
//           and the remainder takes the sign of the dividend. Divide by zero
//           gives lo = all ones, hi = dividend (no trap).
//
// Build option:
//   MULDIV_FAST_MUL_EN  - when defined, MULT/MULTU load a single-cycle product
//                         straight into the FIN staging register, so busy is
//                         high for one cycle. Divide stays iterative.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start, md_op   begin operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   op_a, op_b     rs / rt operands (dividend / divisor for divides)
//   mthi, mtlo     write wdata to HI / LO when idle and start is low
//   wdata          MTHI/MTLO data
//   busy           operation in progress (registered)
//   done           one-cycle pulse when HI/LO take a new result (registered)
//   hi, lo         HI and LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_COUNT = 6'(WIDTH - 1);

    state_t               state_reg;
    logic [5:0]           count_reg;
    // Multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc_reg;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [WIDTH-1:0]     operand_reg;
    logic                 is_div_reg;
    logic                 neg_lo_reg;    // negate product / quotient at FIN
    logic                 neg_hi_reg;    // negate remainder at FIN
    logic                 div_zero_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 busy_reg;
    logic                 done_reg;

    // ---------------- operand conditioning at start ----------------
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign op_signed = ~md_op[0];
    assign a_neg     = op_signed & op_a[WIDTH-1];
    assign b_neg     = op_signed & op_b[WIDTH-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;

`ifdef MULDIV_FAST_MUL_EN
    // Sign- or zero-extend to full width so one unsigned multiply yields the
    // correct low 2*WIDTH bits for both signed and unsigned forms.
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] fast_prod;

    assign ext_a     = {{WIDTH{a_neg}}, op_a};
    assign ext_b     = {{WIDTH{b_neg}}, op_b};
    assign fast_prod = ext_a * ext_b;
`endif

    // ---------------- one multiply iteration ----------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // ---------------- one restoring-divide iteration ----------------
    // The partial remainder always stays below the divisor, so after the
    // shift it fits in WIDTH+1 bits and the subtract result in WIDTH bits.
    logic [WIDTH:0]       div_shift;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_next;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, operand_reg});
    assign div_sub   = div_shift[WIDTH-1:0] - operand_reg;
    assign div_next  = {(div_ok ? div_sub : div_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_ok};

    // ---------------- sign correction for FIN ----------------
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fin_hi;
    logic [WIDTH-1:0]     fin_lo;

    assign prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
    // Divide by zero ends with quotient magnitude all ones; force all ones so
    // the signed form does not negate it. The remainder path already returns
    // the dividend (|a| re-signed with the dividend's sign).
    assign quot_fix = div_zero_reg ? '1
                    : (neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);
    assign rem_fix  = neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH]
                                 : acc_reg[2*WIDTH-1:WIDTH];
    assign fin_hi   = is_div_reg ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    assign fin_lo   = is_div_reg ? quot_fix : prod_fix[WIDTH-1:0];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            acc_reg      <= '0;
            operand_reg  <= '0;
            is_div_reg   <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        is_div_reg   <= md_op[1];
                        div_zero_reg <= (op_b == '0);
                        operand_reg  <= md_op[1] ? b_mag : a_mag;
                        acc_reg      <= {{WIDTH{1'b0}}, (md_op[1] ? a_mag : b_mag)};
                        neg_lo_reg   <= a_neg ^ b_neg;
                        neg_hi_reg   <= a_neg & md_op[1];
                        count_reg    <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= CALC;
`ifdef MULDIV_FAST_MUL_EN
                        // Multiplies bypass CALC: the full signed/unsigned
                        // product is already correct, so no FIN negate.
                        if (!md_op[1]) begin
                            acc_reg    <= fast_prod;
                            neg_lo_reg <= 1'b0;
                            state_reg  <= FIN;
                        end
`endif
                    end else begin
                        // start wins over MTHI/MTLO; busy is low in IDLE
                        if (mthi) begin
                            hi_reg <= wdata;
                        end
                        if (mtlo) begin
                            lo_reg <= wdata;
                        end
                    end
                end

                CALC: begin
                    acc_reg   <= is_div_reg ? div_next : mul_next;
                    count_reg <= count_reg + 6'd1;
                    if (count_reg == LAST_COUNT) begin
                        state_reg <= FIN;
                    end
                end

                FIN: begin
                    hi_reg    <= fin_hi;
                    lo_reg    <= fin_lo;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
